// File: rtl/data_mem_responder.sv
// Data-memory responder: 32-bit big-endian word loads/stores over a byte store,
// with a valid/ready request/response handshake and a programmable wait-state count.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 64,
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2,
    parameter int ALIGN_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                          state, state_nxt;
    logic [3:0]                      cnt;
    logic                            lat_we;
    logic [ADDR_W-1:0]               lat_addr;
    logic [31:0]                     lat_wdata;
    logic [DEPTH_BYTES-1:0][7:0]     mem;
    logic [3:0][ADDR_W-1:0]          baddr;
    logic                            access;
    logic                            misalign;
    logic [31:0]                     rd_word;

    // Byte addresses wrap naturally because DEPTH_BYTES == 2**ADDR_W.
    always_comb begin
        baddr = '0;
        for (int k = 0; k < 4; k++)
            baddr[k] = lat_addr + ADDR_W'(k);
    end

    assign access   = (state == S_WAIT) && (cnt == 4'd0);
    assign misalign = (ALIGN_CHECK != 0) && (lat_addr[1:0] != 2'b00);
    assign rd_word  = {mem[baddr[0]], mem[baddr[1]], mem[baddr[2]], mem[baddr[3]]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == 4'd0) state_nxt = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request latch and wait counter; WAIT ignores new requests entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == S_IDLE && req_valid) begin
            cnt       <= 4'(WAIT_CYCLES);
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end else if (state == S_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (access) begin
            resp_err   <= misalign;
            resp_rdata <= (misalign || lat_we) ? 32'h0 : rd_word;
        end else if (state == S_RESP && resp_ready) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) mem[i] <= 8'h00;
        end else if (access && lat_we && !misalign) begin
            mem[baddr[0]] <= lat_wdata[31:24];
            mem[baddr[1]] <= lat_wdata[23:16];
            mem[baddr[2]] <= lat_wdata[15:8];
            mem[baddr[3]] <= lat_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A (WAIT=2, aligned) and instance B (WAIT=0, unaligned allowed).
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_ready, a_resp_err;
    logic [5:0]  a_req_addr;
    logic [31:0] a_req_wdata, a_resp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_ready, b_resp_err;
    logic [5:0]  b_req_addr;
    logic [31:0] b_req_wdata, b_resp_rdata;

    int checks = 0;
    int failures = 0;

    data_mem_responder #(.DEPTH_BYTES(64), .ADDR_W(6), .WAIT_CYCLES(2), .ALIGN_CHECK(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
    );

    data_mem_responder #(.DEPTH_BYTES(64), .ADDR_W(6), .WAIT_CYCLES(0), .ALIGN_CHECK(0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
    );

    // One full transaction on A with resp_ready high; request fields are scrambled after accept.
    task automatic xact_a(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n = 0;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        a_resp_ready = 1'b1;
        while (!a_req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        a_req_valid = 1'b0; a_req_addr = ~addr; a_req_wdata = ~wdata; a_req_we = ~we;
        lat = 0;
        while (!a_resp_valid && lat < 50) begin @(negedge clk); lat++; end
        rdata = a_resp_rdata; err = a_resp_err;
        @(negedge clk);
    endtask

    task automatic xact_b(input logic we, input logic [5:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n = 0;
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        b_resp_ready = 1'b1;
        while (!b_req_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        b_req_valid = 1'b0; b_req_addr = ~addr; b_req_wdata = ~wdata; b_req_we = ~we;
        lat = 0;
        while (!b_resp_valid && lat < 50) begin @(negedge clk); lat++; end
        rdata = b_resp_rdata; err = b_resp_err;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic er; int lat;
        checks++; if ({a_req_ready, a_resp_valid, a_resp_err} !== 3'b100 || a_resp_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_a: ready/valid/err=%b rdata=%h expected 100 00000000",
                                 {a_req_ready, a_resp_valid, a_resp_err}, a_resp_rdata);
        end
        checks++; if ({b_req_ready, b_resp_valid, b_resp_err} !== 3'b100 || b_resp_rdata !== 32'h0) begin
            failures++; $display("FAIL reset_b: ready/valid/err=%b rdata=%h expected 100 00000000",
                                 {b_req_ready, b_resp_valid, b_resp_err}, b_resp_rdata);
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        xact_a(1'b0, 6'd60, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin
            failures++; $display("FAIL reset_mem_clear: rdata=%h err=%b expected 00000000 0", rd, er);
        end
    endtask

    task automatic test_wrap_unaligned();
        logic [31:0] rd; logic er; int lat;
        xact_b(1'b1, 6'd62, 32'h11223344, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL b_store62: rdata=%h err=%b lat=%0d expected 00000000 0 1", rd, er, lat);
        end
        xact_b(1'b0, 6'd62, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h11223344 || er !== 1'b0 || lat != 1) begin
            failures++; $display("FAIL b_load62: rdata=%h err=%b lat=%0d expected 11223344 0 1", rd, er, lat);
        end
        xact_b(1'b0, 6'd63, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h22334400) begin
            failures++; $display("FAIL b_load63: rdata=%h expected 22334400", rd);
        end
        xact_b(1'b0, 6'd0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h33440000) begin
            failures++; $display("FAIL b_load0: rdata=%h expected 33440000", rd);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        b_resp_ready = 1'b1; b_req_we = 1'b0; b_req_addr = 6'd0; b_req_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (b_req_ready) acc.push_back(cyc);
            @(negedge clk);
        end
        b_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (acc.size() != 4) begin
            failures++; $display("FAIL b2b_count: accepts=%0d expected 4", acc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++; if (acc[i] - acc[i-1] != 3) begin
                    failures++; $display("FAIL b2b_spacing%0d: gap=%0d expected 3", i, acc[i] - acc[i-1]);
                end
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        xact_a(1'b1, 6'd8, 32'hDEADBEEF, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0 || lat != 3) begin
            failures++; $display("FAIL a_store8: rdata=%h err=%b lat=%0d expected 00000000 0 3", rd, er, lat);
        end
        xact_a(1'b0, 6'd8, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat != 3) begin
            failures++; $display("FAIL a_load8: rdata=%h err=%b lat=%0d expected deadbeef 0 3", rd, er, lat);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic er; int lat;
        xact_a(1'b1, 6'd5, 32'hFFFFFFFF, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1 || lat != 3) begin
            failures++; $display("FAIL a_store5_err: rdata=%h err=%b lat=%0d expected 00000000 1 3", rd, er, lat);
        end
        xact_a(1'b0, 6'd4, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin
            failures++; $display("FAIL a_load4_unchanged: rdata=%h err=%b expected 00000000 0", rd, er);
        end
        xact_a(1'b0, 6'd8, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin
            failures++; $display("FAIL a_load8_unchanged: rdata=%h expected deadbeef", rd);
        end
        xact_a(1'b0, 6'd10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || er !== 1'b1) begin
            failures++; $display("FAIL a_load10_err: rdata=%h err=%b expected 00000000 1", rd, er);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n = 0;
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 6'd8; a_req_wdata = 32'h0;
        @(negedge clk);
        a_req_we = 1'b1; a_req_wdata = 32'h55555555;
        while (!a_resp_valid && n < 50) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (a_resp_valid !== 1'b1 || a_resp_rdata !== 32'hDEADBEEF || a_req_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold%0d: valid=%b rdata=%h ready=%b expected 1 deadbeef 0",
                                     i, a_resp_valid, a_resp_rdata, a_req_ready);
            end
            @(negedge clk);
        end
        a_req_valid = 1'b0; a_resp_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_resp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_resp_rdata !== 32'h0) begin
            failures++; $display("FAIL bp_retire: valid=%b ready=%b rdata=%h expected 0 1 00000000",
                                 a_resp_valid, a_req_ready, a_resp_rdata);
        end
        xact_a(1'b0, 6'd8, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin
            failures++; $display("FAIL bp_ignored_store: rdata=%h expected deadbeef", rd);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] rd; logic er; int lat;
        a_resp_ready = 1'b1;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 6'd12; a_req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (a_req_ready !== 1'b1 || a_resp_valid !== 1'b0 || a_resp_rdata !== 32'h0) begin
            failures++; $display("FAIL midop_reset: ready=%b valid=%b rdata=%h expected 1 0 00000000",
                                 a_req_ready, a_resp_valid, a_resp_rdata);
        end
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        xact_a(1'b0, 6'd12, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0 || lat != 3) begin
            failures++; $display("FAIL midop_load12: rdata=%h lat=%0d expected 00000000 3", rd, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_resp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        test_reset();
        test_wrap_unaligned();
        test_back_to_back();
        test_store_load();
        test_misaligned();
        test_backpressure();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
